// File: rtl/ft245_pkg.sv
// Shared encodings and defaults for the FT245-style asynchronous FIFO responder.
package ft245_pkg;

  localparam int DEFAULT_DEPTH     = 16;
  localparam int DEFAULT_PRECHARGE = 2;

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_DRIVE   = 2'd1,
    R_RECOVER = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_STROBE  = 2'd1,
    W_RECOVER = 2'd2
  } wr_state_t;

  // Observation bundle: both FSM states plus the bus output-enable.
  typedef struct packed {
    rd_state_t rd_state;
    wr_state_t wr_state;
    logic      oe;
  } dbg_t;

endpackage

// File: rtl/ft245_byte_fifo.sv
// Synchronous 8-bit FIFO with occupancy output. Pushes while full and pops
// while empty are ignored; a simultaneous push and pop leaves the level as is.
module ft245_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   in_clk,
  input  logic                   in_rst,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Pointers wrap naturally modulo DEPTH; count tracks push/pop balance.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge in_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ft245_async_responder.sv
// Device side of an FT245-style asynchronous byte interface. A read FIFO
// feeds bytes to the host over io_ftdi_data; a write FIFO collects bytes the
// host strobes in. Local streams use valid/ready: a byte moves on every
// rising clock where valid and ready are both high; valid never waits on ready.
module ft245_async_responder
  import ft245_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int PRECHARGE = DEFAULT_PRECHARGE
) (
  input  logic                   in_clk,
  input  logic                   in_rst,
  input  logic                   in_ftdi_rd,
  input  logic                   in_ftdi_wr,
  inout  wire  [7:0]             io_ftdi_data,
  output logic                   out_ftdi_rxf,
  output logic                   out_ftdi_txe,
  input  logic [7:0]             in_src_data,
  input  logic                   in_src_valid,
  output logic                   out_src_ready,
  output logic [7:0]             out_snk_data,
  output logic                   out_snk_valid,
  input  logic                   in_snk_ready,
  output logic [$clog2(DEPTH):0] out_rd_level,
  output logic [$clog2(DEPTH):0] out_wr_level,
  output logic                   out_err_underrun,
  output logic                   out_err_overrun,
  output logic                   out_err_conflict,
  output dbg_t                   dbg
);

  localparam int CW = $clog2(PRECHARGE + 1);

  logic          rd_q, wr_q, rd_prev, wr_prev, primed;
  logic [7:0]    data_q;
  logic          rd_rise, rd_fall, wr_rise, wr_fall, conflict;
  rd_state_t     rd_state, rd_state_d;
  wr_state_t     wr_state, wr_state_d;
  logic [CW-1:0] rd_cnt, rd_cnt_d, wr_cnt, wr_cnt_d;
  logic          rd_pop, wr_push, drive, oe, set_underrun, set_overrun;
  logic [7:0]    rd_head;
  logic          rd_full, rd_empty, wr_full, wr_empty;

  // Single-stage input registers. The first clock after reset loads the
  // history with the live strobe so a strobe held through reset is not an edge.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_prev <= 1'b0;
      wr_prev <= 1'b0;
      primed  <= 1'b0;
      data_q  <= '0;
    end else begin
      primed  <= 1'b1;
      rd_q    <= in_ftdi_rd;
      wr_q    <= in_ftdi_wr;
      data_q  <= io_ftdi_data;
      rd_prev <= primed ? rd_q : in_ftdi_rd;
      wr_prev <= primed ? wr_q : in_ftdi_wr;
    end
  end

  assign rd_rise  = rd_q && !rd_prev;
  assign rd_fall  = !rd_q && rd_prev;
  assign wr_rise  = wr_q && !wr_prev;
  assign wr_fall  = !wr_q && wr_prev;
  assign conflict = rd_q && wr_q;

  // FSM state registers with their precharge counters.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
    end else begin
      rd_state <= rd_state_d;
      wr_state <= wr_state_d;
      rd_cnt   <= rd_cnt_d;
      wr_cnt   <= wr_cnt_d;
    end
  end

  // Read FSM: advertise data, drive the head byte while strobed, pop on release.
  always_comb begin
    rd_state_d   = rd_state;
    rd_cnt_d     = rd_cnt;
    rd_pop       = 1'b0;
    drive        = 1'b0;
    out_ftdi_rxf = 1'b0;
    set_underrun = 1'b0;
    case (rd_state)
      R_IDLE: begin
        out_ftdi_rxf = !rd_empty;
        if (rd_rise) begin
          if (!rd_empty) rd_state_d = R_DRIVE;
          else           set_underrun = 1'b1;
        end
      end
      R_DRIVE: begin
        drive = !rd_fall;
        if (rd_fall) begin
          rd_pop     = 1'b1;
          rd_state_d = R_RECOVER;
          rd_cnt_d   = '0;
        end
      end
      R_RECOVER: begin
        if (rd_cnt == CW'(PRECHARGE - 1)) rd_state_d = R_IDLE;
        else                              rd_cnt_d   = rd_cnt + 1'b1;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write FSM: capture on strobe rise, hold txe low through strobe and precharge.
  always_comb begin
    wr_state_d   = wr_state;
    wr_cnt_d     = wr_cnt;
    wr_push      = 1'b0;
    out_ftdi_txe = 1'b0;
    set_overrun  = wr_rise && wr_full;
    case (wr_state)
      W_IDLE: begin
        out_ftdi_txe = !wr_full;
        if (wr_rise && !wr_full) begin
          wr_push    = 1'b1;
          wr_state_d = W_STROBE;
        end
      end
      W_STROBE: begin
        if (wr_fall) begin
          wr_state_d = W_RECOVER;
          wr_cnt_d   = '0;
        end
      end
      W_RECOVER: begin
        if (wr_cnt == CW'(PRECHARGE - 1)) wr_state_d = W_IDLE;
        else                              wr_cnt_d   = wr_cnt + 1'b1;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Sticky protocol error flags, cleared only by reset.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_err_underrun <= 1'b0;
      out_err_overrun  <= 1'b0;
      out_err_conflict <= 1'b0;
    end else begin
      if (set_underrun) out_err_underrun <= 1'b1;
      if (set_overrun)  out_err_overrun  <= 1'b1;
      if (conflict)     out_err_conflict <= 1'b1;
    end
  end

  // Never drive while any write strobe is visible, during a conflict, or in reset.
  assign oe           = drive && !conflict && !wr_q && !in_ftdi_wr && !in_rst;
  assign io_ftdi_data = oe ? rd_head : 8'hzz;

  assign out_src_ready = !rd_full;
  assign out_snk_valid = !wr_empty;
  assign dbg           = '{rd_state: rd_state, wr_state: wr_state, oe: oe};

  ft245_byte_fifo #(.DEPTH(DEPTH)) u_rd_fifo (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .push      (in_src_valid && out_src_ready),
    .push_data (in_src_data),
    .pop       (rd_pop),
    .head      (rd_head),
    .level     (out_rd_level),
    .full      (rd_full),
    .empty     (rd_empty)
  );

  ft245_byte_fifo #(.DEPTH(DEPTH)) u_wr_fifo (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .push      (wr_push),
    .push_data (data_q),
    .pop       (out_snk_valid && in_snk_ready),
    .head      (out_snk_data),
    .level     (out_wr_level),
    .full      (wr_full),
    .empty     (wr_empty)
  );

endmodule

// File: tb/tb_ft245_async_responder.sv
// Bench for ft245_async_responder: directed host strobes and local pushes,
// with a queue-based scoreboard checking bytes as the DUT presents them.
module tb_ft245_async_responder;
  import ft245_pkg::*;

  localparam int DEPTH     = 16;
  localparam int PRECHARGE = 2;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic          in_clk = 1'b0;
  logic          in_rst;
  logic          ftdi_rd, ftdi_wr;
  wire  [7:0]    ftdi_data;
  logic [7:0]    host_data;
  logic          host_drive;
  logic          ftdi_rxf, ftdi_txe;
  logic [7:0]    src_data;
  logic          src_valid, src_ready;
  logic [7:0]    snk_data;
  logic          snk_valid, snk_ready;
  logic [LW-1:0] rd_level, wr_level;
  logic          err_underrun, err_overrun, err_conflict;
  dbg_t          dbg;

  int total = 0;
  int bad   = 0;
  logic [7:0] rd_exp_q[$];
  logic [7:0] snk_exp_q[$];

  assign ftdi_data = host_drive ? host_data : 8'hzz;

  ft245_async_responder #(.DEPTH(DEPTH), .PRECHARGE(PRECHARGE)) dut (
    .in_clk           (in_clk),
    .in_rst           (in_rst),
    .in_ftdi_rd       (ftdi_rd),
    .in_ftdi_wr       (ftdi_wr),
    .io_ftdi_data     (ftdi_data),
    .out_ftdi_rxf     (ftdi_rxf),
    .out_ftdi_txe     (ftdi_txe),
    .in_src_data      (src_data),
    .in_src_valid     (src_valid),
    .out_src_ready    (src_ready),
    .out_snk_data     (snk_data),
    .out_snk_valid    (snk_valid),
    .in_snk_ready     (snk_ready),
    .out_rd_level     (rd_level),
    .out_wr_level     (wr_level),
    .out_err_underrun (err_underrun),
    .out_err_overrun  (err_overrun),
    .out_err_conflict (err_conflict),
    .dbg              (dbg)
  );

  // Clock and watchdog
  always #5 in_clk = ~in_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: bus byte at the start of each drive, sink byte on handshake.
  logic oe_prev = 1'b0;
  always @(negedge in_clk) begin
    if (dbg.oe && !oe_prev) begin
      if (rd_exp_q.size() == 0) chk("rd_queue_depth", rd_exp_q.size(), 1);
      else                      chk("rd_byte", ftdi_data, rd_exp_q.pop_front());
    end
    oe_prev <= dbg.oe;
    if (snk_valid && snk_ready) begin
      if (snk_exp_q.size() == 0) chk("snk_queue_depth", snk_exp_q.size(), 1);
      else                       chk("snk_byte", snk_data, snk_exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic src_push(input logic [7:0] d, input bit to_host);
    chk("src_ready", src_ready, 1);
    src_data  = d;
    src_valid = 1'b1;
    if (to_host) rd_exp_q.push_back(d);
    tick();
    src_valid = 1'b0;
  endtask

  task automatic host_read(input bit expect_drive);
    ftdi_rd = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) chk("oe_early", dbg.oe, 0);
      else begin
        chk("oe_hold", dbg.oe, expect_drive);
        chk("rxf_busy", ftdi_rxf, 0);
      end
    end
    ftdi_rd = 1'b0;
    tick();
    chk("oe_drop", dbg.oe, 0);
    for (int k = 0; k < PRECHARGE; k++) begin
      tick();
      chk("rxf_precharge", ftdi_rxf, 0);
    end
    tick();
  endtask

  task automatic host_write(input logic [7:0] d, input bit accept);
    host_data  = d;
    host_drive = 1'b1;
    ftdi_wr    = 1'b1;
    if (accept) snk_exp_q.push_back(d);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("oe_during_wr", dbg.oe, 0);
      if (k >= 2) chk("txe_busy", ftdi_txe, 0);
    end
    ftdi_wr    = 1'b0;
    host_drive = 1'b0;
    for (int k = 0; k <= PRECHARGE; k++) begin
      tick();
      chk("txe_precharge", ftdi_txe, 0);
    end
    tick();
  endtask

  // Directed sequence
  initial begin
    in_rst = 1'b1; ftdi_rd = 1'b0; ftdi_wr = 1'b0;
    host_drive = 1'b0; host_data = '0;
    src_valid = 1'b0; src_data = '0; snk_ready = 1'b1;
    repeat (3) @(posedge in_clk);
    #1;
    chk("rst_rxf", ftdi_rxf, 0);
    chk("rst_snk_valid", snk_valid, 0);
    chk("rst_rd_level", rd_level, 0);
    chk("rst_wr_level", wr_level, 0);
    chk("rst_flags", {err_underrun, err_overrun, err_conflict}, 0);
    chk("rst_oe", dbg.oe, 0);
    in_rst = 1'b0;
    tick();
    chk("post_rst_txe", ftdi_txe, 1);
    chk("post_rst_src_ready", src_ready, 1);

    // Single host read of 0xA5
    src_push(8'hA5, 1);
    chk("rd_level_one", rd_level, 1);
    chk("rxf_before_rd", ftdi_rxf, 1);
    host_read(1);
    chk("rd_level_zero", rd_level, 0);
    chk("rxf_after_empty", ftdi_rxf, 0);

    // Single host write of 0x3C
    host_write(8'h3C, 1);
    chk("wr_level_drained", wr_level, 0);
    chk("txe_after_write", ftdi_txe, 1);

    // Fill read FIFO across the pointer wrap, then read it all back
    for (int i = 0; i < 16; i++) src_push(8'(i), 1);
    chk("src_ready_full", src_ready, 0);
    chk("rd_level_full", rd_level, 16);
    for (int i = 0; i < 16; i++) host_read(1);
    chk("rd_level_after_drain", rd_level, 0);

    // Fill write FIFO with sink stalled, then overrun
    snk_ready = 1'b0;
    for (int i = 0; i < 16; i++) host_write(8'h40 + 8'(i), 1);
    chk("txe_full", ftdi_txe, 0);
    chk("wr_level_full", wr_level, 16);
    chk("overrun_clear", err_overrun, 0);
    host_write(8'hEE, 0);
    chk("overrun_set", err_overrun, 1);
    chk("wr_level_unchanged", wr_level, 16);
    chk("snk_head_unchanged", snk_data, 8'h40);
    snk_ready = 1'b1;
    for (int c = 0; c < 64 && wr_level != 0; c++) tick();
    chk("wr_level_drain", wr_level, 0);
    chk("snk_queue_empty", snk_exp_q.size(), 0);
    chk("txe_after_drain", ftdi_txe, 1);

    // Underrun: read with empty FIFO
    chk("underrun_clear", err_underrun, 0);
    host_read(0);
    chk("underrun_set", err_underrun, 1);
    chk("conflict_clear", err_conflict, 0);

    // Conflict: read and write strobes overlap with data available
    src_push(8'h99, 0);
    host_data = 8'h5E; host_drive = 1'b1;
    ftdi_rd = 1'b1; ftdi_wr = 1'b1;
    snk_exp_q.push_back(8'h5E);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("oe_conflict", dbg.oe, 0);
    end
    ftdi_rd = 1'b0; ftdi_wr = 1'b0; host_drive = 1'b0;
    repeat (PRECHARGE + 2) tick();
    chk("conflict_set", err_conflict, 1);
    chk("rd_level_conflict", rd_level, 0);
    chk("snk_queue_conflict", snk_exp_q.size(), 0);

    // Reset mid-drive, with the read strobe held across release
    src_push(8'h77, 1);
    ftdi_rd = 1'b1;
    tick();
    tick();
    chk("oe_before_reset", dbg.oe, 1);
    @(negedge in_clk);
    #2;
    in_rst = 1'b1;
    #1;
    chk("oe_async_reset", dbg.oe, 0);
    repeat (2) tick();
    in_rst = 1'b0;
    repeat (4) tick();
    chk("rel_underrun", err_underrun, 0);
    chk("rel_overrun", err_overrun, 0);
    chk("rel_conflict", err_conflict, 0);
    chk("rel_rxf", ftdi_rxf, 0);
    chk("rel_txe", ftdi_txe, 1);
    chk("rel_rd_level", rd_level, 0);
    chk("rel_oe", dbg.oe, 0);
    ftdi_rd = 1'b0;
    repeat (3) tick();

    chk("rd_queue_final", rd_exp_q.size(), 0);
    chk("snk_queue_final", snk_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
